// File: rtl/tcore_param.sv
// rtl/tcore_param.sv - shared fetch types, reset vector and RVC length decode
package tcore_param;

    localparam logic [31:0] RESET_VECTOR = 32'h4000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rdata;
    } fetch_out_t;

    // Low two opcode bits of the first halfword select 32-bit (2'b11) vs compressed.
    function automatic logic is_32bit(input logic [1:0] op);
        return op == 2'b11;
    endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// rtl/fetch_hw_queue.sv - circular halfword FIFO, 0-2 pushes and 0-2 pops per cycle
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   clear_i               drop all contents (redirect)
//   push_cnt_i            halfwords written this cycle (0-2), push_hw0_i first
//   push_hw0_i/push_hw1_i halfword data
//   pop_cnt_i             halfwords removed from the head this cycle (0-2)
//   head_hw0_o/head_hw1_o oldest and second-oldest halfword
//   count_o               halfwords held
module fetch_hw_queue #(
    parameter int DEPTH_HW = 8,
    parameter int CW       = $clog2(DEPTH_HW + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic [1:0]    push_cnt_i,
    input  logic [15:0]   push_hw0_i,
    input  logic [15:0]   push_hw1_i,
    input  logic [1:0]    pop_cnt_i,
    output logic [15:0]   head_hw0_o,
    output logic [15:0]   head_hw1_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH_HW);

    logic [15:0]   mem_q [DEPTH_HW];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(n);
        if (s >= (PW+1)'(DEPTH_HW)) begin
            s = s - (PW+1)'(DEPTH_HW);
        end
        return s[PW-1:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= ptr_add(rd_ptr_q, pop_cnt_i);
            wr_ptr_q <= ptr_add(wr_ptr_q, push_cnt_i);
            count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i) begin
            if (push_cnt_i != 2'd0) begin
                mem_q[wr_ptr_q] <= push_hw0_i;
            end
            if (push_cnt_i == 2'd2) begin
                mem_q[ptr_add(wr_ptr_q, 2'd1)] <= push_hw1_i;
            end
        end
    end

    assign head_hw0_o = mem_q[rd_ptr_q];
    assign head_hw1_o = mem_q[ptr_add(rd_ptr_q, 2'd1)];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_align_queue.sv
// rtl/fetch_align_queue.sv - word fetch requester and RV32IMC instruction aligner
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   flush_i/flush_pc_i redirect and its target (bit 0 ignored)
//   mem_req_*          word-aligned request channel (valid/ready/addr)
//   mem_rsp_*          in-order response word for the oldest in-flight request
//   fetch_*            one aligned instruction per cycle (valid/pc/rdata/ready)
module fetch_align_queue
    import tcore_param::fetch_out_t, tcore_param::is_32bit;
#(
    parameter int          DEPTH_HW     = 8,
    parameter int          MAX_OUT      = 2,
    parameter logic [31:0] RESET_VECTOR = tcore_param::RESET_VECTOR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_rdata_o,
    input  logic        fetch_ready_i
);

    localparam int CW = $clog2(DEPTH_HW + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [CW-1:0] hw_count;
    logic [15:0]   head_hw0;
    logic [15:0]   head_hw1;

    logic [31:0]   head_pc_q;
    logic [31:0]   req_pc_q;
    logic [OW-1:0] out_cnt_q;
    logic [OW-1:0] drop_cnt_q;
    logic          skip_lo_q;

    logic [31:0]   need_hw;
    logic          req_valid;
    logic          req_fire;
    logic          head_is_32;
    logic          insn_valid;
    logic          fetch_fire;
    logic [1:0]    pop_cnt;
    logic          rsp_push;
    logic [1:0]    push_cnt;
    logic [15:0]   push_hw0;
    fetch_out_t    fetch_out;

    // Every in-flight request reserves two halfwords, so a response always fits.
    assign need_hw   = 32'(hw_count) + (32'(out_cnt_q) << 1) + 32'd2;
    assign req_valid = rst_ni && !flush_i && (out_cnt_q < OW'(MAX_OUT))
                       && (need_hw <= 32'(DEPTH_HW));
    assign req_fire  = req_valid && mem_req_ready_i;

    assign head_is_32 = is_32bit(head_hw0[1:0]);
    assign insn_valid = rst_ni && !flush_i
                        && (head_is_32 ? (hw_count >= CW'(2)) : (hw_count != '0));
    assign fetch_fire = insn_valid && fetch_ready_i;
    assign pop_cnt    = !fetch_fire ? 2'd0 : (head_is_32 ? 2'd2 : 2'd1);

    // Responses to requests issued before a redirect are discarded, and a
    // redirect into the upper half of a word skips that word's low halfword.
    assign rsp_push = mem_rsp_valid_i && !flush_i && (drop_cnt_q == '0);
    assign push_cnt = !rsp_push ? 2'd0 : (skip_lo_q ? 2'd1 : 2'd2);
    assign push_hw0 = skip_lo_q ? mem_rsp_data_i[31:16] : mem_rsp_data_i[15:0];

    fetch_hw_queue #(
        .DEPTH_HW (DEPTH_HW),
        .CW       (CW)
    ) u_hw_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_i),
        .push_cnt_i (push_cnt),
        .push_hw0_i (push_hw0),
        .push_hw1_i (mem_rsp_data_i[31:16]),
        .pop_cnt_i  (pop_cnt),
        .head_hw0_o (head_hw0),
        .head_hw1_o (head_hw1),
        .count_o    (hw_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_pc_q  <= RESET_VECTOR;
            req_pc_q   <= RESET_VECTOR;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            skip_lo_q  <= 1'b0;
        end else if (flush_i) begin
            head_pc_q  <= flush_pc_i & 32'hFFFF_FFFE;
            req_pc_q   <= flush_pc_i & 32'hFFFF_FFFC;
            skip_lo_q  <= flush_pc_i[1];
            // No request is issued during a flush; a response in this cycle is dropped.
            out_cnt_q  <= out_cnt_q - OW'(mem_rsp_valid_i);
            drop_cnt_q <= out_cnt_q - OW'(mem_rsp_valid_i);
        end else begin
            out_cnt_q <= out_cnt_q + OW'(req_fire) - OW'(mem_rsp_valid_i);
            if (req_fire) begin
                req_pc_q <= req_pc_q + 32'd4;
            end
            if (fetch_fire) begin
                head_pc_q <= head_pc_q + (head_is_32 ? 32'd4 : 32'd2);
            end
            if (mem_rsp_valid_i && drop_cnt_q != '0) begin
                drop_cnt_q <= drop_cnt_q - OW'(1);
            end
            if (rsp_push) begin
                skip_lo_q <= 1'b0;
            end
        end
    end

    always_comb begin
        fetch_out.valid = 1'b0;
        fetch_out.pc    = RESET_VECTOR;
        fetch_out.rdata = 32'h0;
        if (rst_ni) begin
            fetch_out.valid = insn_valid;
            fetch_out.pc    = head_pc_q;
            fetch_out.rdata = head_is_32 ? {head_hw1, head_hw0} : {16'h0, head_hw0};
        end
    end

    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = req_pc_q;
    assign fetch_valid_o   = fetch_out.valid;
    assign fetch_pc_o      = fetch_out.pc;
    assign fetch_rdata_o   = fetch_out.rdata;

    rsp_without_request: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(mem_rsp_valid_i && out_cnt_q == '0)
    );

endmodule

// File: tb/tb_fetch_align_queue.sv
// tb/tb_fetch_align_queue.sv - self-checking bench for fetch_align_queue
module tb_fetch_align_queue;

    localparam int          DEPTH_HW = 8;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RV       = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_rdata;
    logic        f_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc;
    logic [31:0] m_req;
    logic [31:0] pending[$];
    int          consumed;

    always #5 clk = ~clk;

    fetch_align_queue #(
        .DEPTH_HW     (DEPTH_HW),
        .MAX_OUT      (MAX_OUT),
        .RESET_VECTOR (RV)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .flush_pc_i      (flush_pc),
        .mem_req_valid_o (req_valid),
        .mem_req_ready_i (req_ready),
        .mem_req_addr_o  (req_addr),
        .mem_rsp_valid_i (rsp_valid),
        .mem_rsp_data_i  (rsp_data),
        .fetch_valid_o   (f_valid),
        .fetch_pc_o      (f_pc),
        .fetch_rdata_o   (f_rdata),
        .fetch_ready_i   (f_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] x;
        x = a ^ 32'h5bd1_e995;
        x = x * 32'h9e37_79b1;
        x = x ^ (x >> 15);
        return x;
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; flush_pc = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; f_ready = 1'b0;
        pending.delete();
        m_pc = RV; m_req = RV; consumed = 0;
        @(negedge clk);
        #1;
        if (check) begin
            tests++;
            if (req_valid !== 1'b0 || f_valid !== 1'b0 || f_pc !== RV || f_rdata !== 32'h0) begin
                fails++;
                $display("FAIL reset_outputs: req_valid=%b fetch_valid=%b pc=%h rdata=%h expected 0 0 %h 0",
                         req_valid, f_valid, f_pc, f_rdata, RV);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic accept_req(input logic [31:0] exp_addr, input string nm);
        req_ready = 1'b1;
        #1;
        tests++;
        if (req_valid !== 1'b1 || req_addr !== exp_addr) begin
            fails++;
            $display("FAIL %s: req_valid=%b addr=%h expected valid=1 addr=%h", nm, req_valid, req_addr, exp_addr);
        end
        @(negedge clk);
        req_ready = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] d);
        rsp_valid = 1'b1;
        rsp_data  = d;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = '0;
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] rd, input string nm);
        f_ready = 1'b1;
        #1;
        tests++;
        if (f_valid !== 1'b1 || f_pc !== pc || f_rdata !== rd) begin
            fails++;
            $display("FAIL %s: valid=%b pc=%h rdata=%h expected valid=1 pc=%h rdata=%h",
                     nm, f_valid, f_pc, f_rdata, pc, rd);
        end
        @(negedge clk);
        f_ready = 1'b0;
    endtask

    task automatic expect_idle(input string nm);
        #1;
        tests++;
        if (f_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s: fetch_valid=%b expected 0", nm, f_valid);
        end
    endtask

    task automatic do_flush(input logic [31:0] tgt, input bit with_rsp, input logic [31:0] d, input string nm);
        flush = 1'b1; flush_pc = tgt;
        rsp_valid = with_rsp; rsp_data = d;
        #1;
        tests++;
        if (req_valid !== 1'b0 || f_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s: req_valid=%b fetch_valid=%b expected 0 0 during flush", nm, req_valid, f_valid);
        end
        @(negedge clk);
        flush = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    endtask

    // Random traffic against a program-order model: the instruction stream seen
    // by the consumer must equal sequential decode of mem_word() from the last target.
    task automatic run_traffic(input int ncyc, input int p_fetch, input int p_mreq,
                               input int p_rsp, input int p_flush, output int n_acc);
        logic [15:0] h0;
        logic [31:0] exp_rd;
        logic [31:0] step;
        n_acc = 0;
        for (int c = 0; c < ncyc; c++) begin
            flush = ($urandom_range(99) < p_flush);
            if (flush) begin
                flush_pc = RV + 32'($urandom_range(255)) * 32'd2 + 32'($urandom_range(1));
            end
            req_ready = ($urandom_range(99) < p_mreq);
            f_ready   = ($urandom_range(99) < p_fetch);
            if (pending.size() > 0 && $urandom_range(99) < p_rsp) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_word(pending.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
            #1;
            if (flush) begin
                tests++;
                if (f_valid !== 1'b0 || req_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_flush_gate: fetch_valid=%b req_valid=%b expected 0 0", f_valid, req_valid);
                end
                m_pc  = flush_pc & 32'hFFFF_FFFE;
                m_req = flush_pc & 32'hFFFF_FFFC;
            end else begin
                if (f_valid === 1'b1 && f_ready) begin
                    h0 = hw_at(m_pc);
                    if (h0[1:0] == 2'b11) begin
                        exp_rd = {hw_at(m_pc + 32'd2), h0};
                        step   = 32'd4;
                    end else begin
                        exp_rd = {16'h0, h0};
                        step   = 32'd2;
                    end
                    tests++;
                    if (f_pc !== m_pc || f_rdata !== exp_rd) begin
                        fails++;
                        $display("FAIL rand_fetch: pc=%h rdata=%h expected pc=%h rdata=%h", f_pc, f_rdata, m_pc, exp_rd);
                    end
                    m_pc = m_pc + step;
                    consumed++;
                end
                if (req_valid === 1'b1 && req_ready) begin
                    tests++;
                    if (req_addr !== m_req || pending.size() >= MAX_OUT) begin
                        fails++;
                        $display("FAIL rand_req: addr=%h inflight=%0d expected addr=%h inflight<%0d",
                                 req_addr, pending.size(), m_req, MAX_OUT);
                    end
                    pending.push_back(m_req);
                    m_req = m_req + 32'd4;
                    n_acc++;
                end
            end
            @(negedge clk);
        end
        flush = 1'b0; req_ready = 1'b0; f_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
    endtask

    task automatic test_aligned_word();
        do_reset(1'b0);
        accept_req(RV, "t1_req");
        expect_idle("t1_empty");
        send_rsp(32'h0010_0093);
        expect_fetch(RV, 32'h0010_0093, "t1_fetch");
        expect_idle("t1_drained");
    endtask

    task automatic test_compressed_pair();
        do_reset(1'b0);
        accept_req(RV, "t2_req");
        send_rsp(32'h4501_4505);
        expect_fetch(RV, 32'h0000_4505, "t2_first");
        expect_fetch(RV + 32'd2, 32'h0000_4501, "t2_second");
        expect_idle("t2_drained");
    endtask

    task automatic test_straddle();
        do_reset(1'b0);
        accept_req(RV, "t3_req0");
        accept_req(RV + 32'd4, "t3_req1");
        send_rsp(32'h0093_0001);
        expect_fetch(RV, 32'h0000_0001, "t3_c16");
        expect_idle("t3_wait_half");
        send_rsp(32'h4505_0010);
        expect_fetch(RV + 32'd2, 32'h0010_0093, "t3_straddle");
        expect_fetch(RV + 32'd6, 32'h0000_4505, "t3_tail");
    endtask

    task automatic test_flush_drop();
        do_reset(1'b0);
        accept_req(RV, "t4_req0");
        accept_req(RV + 32'd4, "t4_req1");
        do_flush(32'h4000_0200, 1'b0, '0, "t4_flush");
        send_rsp(32'h1111_1111);
        expect_idle("t4_drop0");
        send_rsp(32'h2222_2222);
        expect_idle("t4_drop1");
        accept_req(32'h4000_0200, "t4_req_target");
        send_rsp(32'h40a5_4505);
        expect_fetch(32'h4000_0200, 32'h0000_4505, "t4_fetch");
    endtask

    task automatic test_flush_odd();
        do_reset(1'b0);
        do_flush(32'h4000_0102, 1'b0, '0, "t5_flush");
        accept_req(32'h4000_0100, "t5_req");
        send_rsp(32'h4505_0001);
        expect_fetch(32'h4000_0102, 32'h0000_4505, "t5_fetch");
        expect_idle("t5_single");
    endtask

    task automatic test_back_to_back_flush();
        do_reset(1'b0);
        accept_req(RV, "b2b_req0");
        accept_req(RV + 32'd4, "b2b_req1");
        do_flush(32'h4000_0300, 1'b0, '0, "b2b_flush_a");
        do_flush(32'h4000_0403, 1'b1, 32'h3333_3333, "b2b_flush_b");
        send_rsp(32'h4444_4444);
        expect_idle("b2b_drop");
        accept_req(32'h4000_0400, "b2b_req_target");
        send_rsp(32'h1234_4507);
        expect_fetch(32'h4000_0402, 32'h0000_1234, "b2b_fetch");
        expect_idle("b2b_single");
    endtask

    task automatic test_backpressure();
        int acc;
        do_reset(1'b0);
        run_traffic(40, 0, 100, 100, 0, acc);
        tests++;
        if (acc != 4) begin
            fails++;
            $display("FAIL t6_stall_requests: accepted=%0d expected 4", acc);
        end
        run_traffic(300, 70, 100, 100, 0, acc);
        tests++;
        if (consumed < 4) begin
            fails++;
            $display("FAIL t6_resume: consumed=%0d expected >=4", consumed);
        end
    endtask

    task automatic test_random();
        int acc;
        do_reset(1'b0);
        run_traffic(3000, 60, 60, 50, 2, acc);
        tests++;
        if (consumed < 100) begin
            fails++;
            $display("FAIL rand_progress: consumed=%0d expected >=100", consumed);
        end
    endtask

    task automatic test_reset_mid_stream();
        int acc;
        run_traffic(25, 40, 100, 100, 0, acc);
        rst_n = 1'b0;
        pending.delete();
        @(negedge clk);
        #1;
        tests++;
        if (req_valid !== 1'b0 || f_valid !== 1'b0 || f_pc !== RV || f_rdata !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: req_valid=%b fetch_valid=%b pc=%h rdata=%h expected 0 0 %h 0",
                     req_valid, f_valid, f_pc, f_rdata, RV);
        end
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("mid_reset_queue_empty");
        accept_req(RV, "mid_reset_req");
        send_rsp(32'h0010_0093);
        expect_fetch(RV, 32'h0010_0093, "mid_reset_fetch");
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_compressed_pair();
        test_straddle();
        test_flush_drop();
        test_flush_odd();
        test_back_to_back_flush();
        test_backpressure();
        test_random();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
